// File: rtl/lms_weight_update_pkg.sv
// Shared definitions for the LMS weight updater: default sizes, FSM states
// and the signed 32-bit saturation limits.
package lms_pkg;
   localparam int NTAPS    = 16;
   localparam int XW       = 14;
   localparam int WW       = 32;
   localparam int MU_SHIFT = 12;

   localparam logic [31:0] WMAX = 32'h7FFF_FFFF;
   localparam logic [31:0] WMIN = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
endpackage

// File: rtl/lms_weight_update_tap_mac.sv
// One-tap LMS arithmetic: w + sat((e * x) >>> MU_SHIFT), clamped to the
// signed weight range; o_ovf flags a clamped add.
module lms_tap_mac
   import lms_pkg::*;
#(
   parameter int WW       = lms_pkg::WW,
   parameter int XW       = lms_pkg::XW,
   parameter int MU_SHIFT = lms_pkg::MU_SHIFT
) (
   input  logic signed [WW-1:0] i_e,
   input  logic signed [XW-1:0] i_x,
   input  logic signed [WW-1:0] i_w,
   output logic signed [WW-1:0] o_w,
   output logic                 o_ovf
);
   localparam int PW = WW + XW;
   localparam logic [WW-1:0] SMAX = {1'b0, {(WW-1){1'b1}}};
   localparam logic [WW-1:0] SMIN = {1'b1, {(WW-1){1'b0}}};

   logic signed [PW-1:0] w_p;
   logic signed [PW-1:0] w_d;
   logic signed [WW-1:0] w_dsat;
   logic signed [WW:0]   w_sum;
   logic                 w_dfits;

   assign w_p = PW'(i_e) * PW'(i_x);
   assign w_d = w_p >>> MU_SHIFT;

   // delta fits in WW bits when all bits above the WW-1 sign position agree
   assign w_dfits = (&w_d[PW-1:WW-1]) || ~(|w_d[PW-1:WW-1]);
   assign w_dsat  = w_dfits ? w_d[WW-1:0] : (w_d[PW-1] ? SMIN : SMAX);

   assign w_sum = {i_w[WW-1], i_w} + {w_dsat[WW-1], w_dsat};
   assign o_ovf = w_sum[WW] ^ w_sum[WW-1];
   assign o_w   = o_ovf ? (w_sum[WW] ? SMIN : SMAX) : w_sum[WW-1:0];
endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient updater: latches e and the taps on start, then updates one
// weight per cycle through a single shared MAC.
module lms_weight_update
   import lms_pkg::*;
#(
   parameter int          NTAPS       = lms_pkg::NTAPS,
   parameter int          XW          = lms_pkg::XW,
   parameter int          WW          = lms_pkg::WW,
   parameter int          MU_SHIFT    = lms_pkg::MU_SHIFT,
   parameter logic [31:0] WEIGHT_INIT = 32'd0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   freeze,
   input  logic                   start,
   input  logic [WW-1:0]          e,
   input  logic [NTAPS*XW-1:0]    reff_bus,
   output logic [NTAPS*WW-1:0]    weight_bus,
   output logic                   busy,
   output logic                   done,
   output logic                   sat_flag
);
   localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

   state_t               r_state;
   logic [IW-1:0]        r_idx;
   logic signed [WW-1:0] r_e;
   logic signed [XW-1:0] r_x [NTAPS];
   logic signed [WW-1:0] r_w [NTAPS];
   logic                 r_busy;
   logic                 r_done;
   logic                 r_sat;

   logic signed [WW-1:0] w_new;
   logic                 w_ovf;

   lms_tap_mac #(.WW(WW), .XW(XW), .MU_SHIFT(MU_SHIFT)) u_mac (
      .i_e   (r_e),
      .i_x   (r_x[r_idx]),
      .i_w   (r_w[r_idx]),
      .o_w   (w_new),
      .o_ovf (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sat   <= 1'b0;
         for (int i = 0; i < NTAPS; i++) r_w[i] <= WW'(WEIGHT_INIT);
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !freeze) begin
                  r_e <= e;
                  for (int i = 0; i < NTAPS; i++) r_x[i] <= reff_bus[i*XW +: XW];
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= UPDATE;
               end
            end
            UPDATE: begin
               r_w[r_idx] <= w_new;
               if (w_ovf) r_sat <= 1'b1;
               if (r_idx == IW'(NTAPS-1)) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NTAPS; g++) begin : g_wbus
      assign weight_bus[g*WW +: WW] = r_w[g];
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign sat_flag = r_sat;
endmodule
